// File: rtl/duty_readout_pkg.sv
// duty_readout_pkg: shared address map, status bit positions and FSM states
package duty_readout_pkg;
  localparam logic [2:0] ADDR_HIGH_L = 3'd0;
  localparam logic [2:0] ADDR_HIGH_H = 3'd1;
  localparam logic [2:0] ADDR_LOW_L  = 3'd2;
  localparam logic [2:0] ADDR_LOW_H  = 3'd3;
  localparam logic [2:0] ADDR_TEST_L = 3'd4;
  localparam logic [2:0] ADDR_TEST_H = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;
  localparam int ST_IRQ     = 0;
  localparam int ST_OVR     = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_SEQ_LSB = 8;
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, PEND} state_t;
endpackage

// File: rtl/duty_readout_regs_if.sv
// duty_readout_regs_if: processor read bus and interrupt of the readout block
interface duty_readout_regs_if;
  logic [2:0]  addr;
  logic        rd_stb;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        irq;
  modport master (output addr, rd_stb, input rd_data, rd_valid, irq);
  modport slave  (input addr, rd_stb, output rd_data, rd_valid, irq);
endinterface

// File: rtl/duty_readout_regs_sync.sv
// sync_fall_detect: 2-flop synchroniser with a registered 1->0 edge pulse
module sync_fall_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic fall
);
  logic s1_q, s2_q, fall_q, fall_d;
  always_comb fall_d = s2_q & ~s1_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      fall_q <= fall_d;
    end
  assign fall = fall_q;
endmodule

// File: rtl/duty_readout_regs.sv
// duty_readout_regs: snapshots duty-cycle counts after each gate window and serves half-word reads
module duty_readout_regs
  import duty_readout_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SEQ_W         = 8
) (
  input  logic                       clk_base,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       gate_in,
  input  logic [31:0]                cnt_high_in,
  input  logic [31:0]                cnt_low_in,
  input  logic [31:0]                cnt_test_in,
  duty_readout_regs_if.slave         bus
);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  logic             fall, fall_ok, rd_sts, busy;
  logic [15:0]      status;
  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [31:0]      high_q, high_d, low_q, low_d, test_q, test_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             irq_q, irq_d, ovr_q, ovr_d, rd_valid_q, rd_valid_d;
  logic [15:0]      rd_data_q, rd_data_d;
  sync_fall_detect u_sync (.clk(clk_base), .rst_n(rst_n), .d(gate_in), .fall(fall));
  always_comb begin
    fall_ok = fall & en;
    rd_sts  = bus.rd_stb && bus.addr == ADDR_STATUS;
    busy    = state_q == SETTLE || state_q == CAPTURE;
    state_d = state_q;
    high_d  = high_q;
    low_d   = low_q;
    test_d  = test_q;
    seq_d   = seq_q;
    cnt_d   = state_q == SETTLE ? cnt_q - 8'd1 : SETTLE_LOAD;
    case (state_q)
      IDLE:    state_d = fall_ok ? SETTLE : IDLE;
      SETTLE:  state_d = cnt_q == 8'd0 ? CAPTURE : SETTLE;
      CAPTURE: begin
        high_d  = cnt_high_in;
        low_d   = cnt_low_in;
        test_d  = cnt_test_in;
        seq_d   = seq_q + 1'b1;
        state_d = PEND;
      end
      default: state_d = rd_sts ? (fall_ok ? SETTLE : IDLE) : PEND;
    endcase
    // a fall racing a status read in PEND starts a fresh window rather than an overrun
    irq_d = state_q == CAPTURE || (irq_q && !rd_sts);
    ovr_d = (fall_ok && (busy || (state_q == PEND && !rd_sts))) ? 1'b1 : rd_sts ? 1'b0 : ovr_q;
    status = '0;
    status[ST_IRQ]  = irq_q;
    status[ST_OVR]  = ovr_q;
    status[ST_BUSY] = busy;
    status[ST_SEQ_LSB +: 8] = 8'(seq_q);
    rd_valid_d = bus.rd_stb;
    rd_data_d  = rd_data_q;
    if (bus.rd_stb)
      case (bus.addr)
        ADDR_HIGH_L: rd_data_d = high_q[15:0];
        ADDR_HIGH_H: rd_data_d = high_q[31:16];
        ADDR_LOW_L:  rd_data_d = low_q[15:0];
        ADDR_LOW_H:  rd_data_d = low_q[31:16];
        ADDR_TEST_L: rd_data_d = test_q[15:0];
        ADDR_TEST_H: rd_data_d = test_q[31:16];
        ADDR_STATUS: rd_data_d = status;
        default:     rd_data_d = 16'h0000;
      endcase
  end
  always_ff @(posedge clk_base or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      high_q     <= '0;
      low_q      <= '0;
      test_q     <= '0;
      seq_q      <= '0;
      irq_q      <= 1'b0;
      ovr_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_q     <= high_d;
      low_q      <= low_d;
      test_q     <= test_d;
      seq_q      <= seq_d;
      irq_q      <= irq_d;
      ovr_q      <= ovr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.irq      = irq_q;
endmodule
